microop_sequencer: RTL
======================

Name: microop_sequencer

Overview:
- Sequences the microcode ROM: owns the opcode register and the micro-op counter, and drives the 11-bit microcode address {opcode[5:0], count[4:0]}.
- Consumes the misc-plane, in-plane and opcode-select fields of the current control word, plus the opword and the bus.
- Adds boot gating, datapath stall, debug halt/single-step at instruction boundaries, and runaway-counter fault recovery.
- Sits between control_logic and the microcode ROM.

Parameters:
RESET_OPCODE, 0, opcode forced on reset, boot, or fault
FETCH_OPCODE, 1, opcode whose load marks an instruction boundary
IN_OPCODE_SEL, 6, in_plane encoding meaning "write opcode register"

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous active-high reset
N_BOOTED  input  1  low once bootstrap has finished; high holds the sequencer in BOOT
CTRL_MISC  input  1  control word bit 15, reset micro-op counter
CTRL_IN_PLANE  input  3  control word bits 14:12
CTRL_OPCODE_SEL  input  1  control word bit 22; 0 = opword, 1 = bus
OPWORD_OPCODE  input  6  opword[31:26]
BUS_LOW  input  6  bus[5:0]
STALL  input  1  datapath not ready (e.g. MMU); freezes sequencing
HALT_REQ  input  1  level; halt at next instruction boundary
STEP_MODE  input  1  halt at every instruction boundary
STEP  input  1  single-cycle pulse; release from HALTED for one instruction
FAULT_CLR  input  1  clears sticky FAULT
UADDR  output  11  microcode address {OPCODE, COUNT}
OPCODE  output  6  opcode register
COUNT  output  5  micro-op counter
UOP_VALID  output  1  current control word may take effect this cycle
HALTED  output  1  in HALTED state
BOUNDARY  output  1  one-cycle pulse, FETCH opcode committed this cycle
FAULT  output  1  sticky counter overflow flag

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous, active-high.
- Reset values: state = BOOT, OPCODE = RESET_OPCODE, COUNT = 0, FAULT = 0, BOUNDARY = 0, HALTED = 0, UOP_VALID = 0.
- Combinational outputs: UADDR = {OPCODE, COUNT}. UOP_VALID = (state == RUN) && !STALL. HALTED = (state == HALTED).
- States: BOOT, RUN, HALTED.
- BOOT:
  - OPCODE and COUNT held at RESET_OPCODE/0.
  - Go to RUN on the first edge that samples N_BOOTED = 0.
- Any state: N_BOOTED = 1 sampled returns to BOOT next edge, forcing RESET_OPCODE/0. This applies mid-instruction. FAULT is unchanged.
- RUN, STALL = 1: no register changes, BOUNDARY = 0.
- RUN, STALL = 0, evaluated in priority order:
  1. Overflow: COUNT == 31 && !CTRL_MISC → OPCODE = RESET_OPCODE, COUNT = 0, FAULT = 1. No opcode write occurs even if requested.
  2. Otherwise COUNT = CTRL_MISC ? 0 : COUNT + 1.
  3. If CTRL_IN_PLANE == IN_OPCODE_SEL: OPCODE = CTRL_OPCODE_SEL ? BUS_LOW : OPWORD_OPCODE. An opcode write without CTRL_MISC is legal and the count still increments.
  4. Boundary: an opcode write whose loaded value == FETCH_OPCODE with CTRL_MISC = 1 → BOUNDARY = 1 that cycle (combinational on the committing cycle).
  5. If a boundary occurs and (HALT_REQ || STEP_MODE) → next state HALTED, with registers loaded to FETCH_OPCODE/0.
- HALTED:
  - Registers frozen, UOP_VALID = 0.
  - STEP = 1 → RUN. The instruction runs to its next boundary and re-halts if STEP_MODE or HALT_REQ is still set.
  - Or HALT_REQ = 0 && STEP_MODE = 0 → RUN.
  - STEP has priority and is ignored outside HALTED.
- FAULT:
  - Set by overflow; stays set until FAULT_CLR or RST.
  - Overflow and FAULT_CLR on the same edge: FAULT = 1 (set wins).
- Latency:
  - Register updates appear on UADDR one cycle after the committing edge.
  - STALL has zero-cycle effect on UOP_VALID.
- Widths: COUNT arithmetic is 5-bit. Wrap is never taken because overflow takes priority.
- BUS_LOW values ≥ 64 are impossible by construction. Any 6-bit opcode is accepted.

Test Plan:
1. RST pulse with N_BOOTED = 1 for 5 cycles → UADDR = 0x000, UOP_VALID = 0. Drop N_BOOTED; feed the RESET word-1 fields (MISC = 1, IN_PLANE = 6, SEL = 1, BUS_LOW = 1) at count 1 → UADDR = 0x020, BOUNDARY pulses once.
2. In FETCH, run counts 0..3 with MISC = 0, then count 4 with MISC = 1, IN_PLANE = 6, SEL = 0, OPWORD_OPCODE = 2 → UADDR sequence 0x020, 0x021, 0x022, 0x023, 0x024, 0x040. No BOUNDARY on the 0x040 load.
3. Hold STALL = 1 for 3 cycles at UADDR 0x022 → UADDR stays 0x022, UOP_VALID = 0. After release, the next edge → 0x023.
4. Opcode 5 with MISC never asserted for 32 cycles → at COUNT = 31 the next edge gives UADDR = 0x000, FAULT = 1. FAULT_CLR asserted on that same edge → FAULT stays 1; FAULT_CLR alone on the next edge → FAULT = 0.
5. STEP_MODE = 1 → halts at UADDR 0x020 with HALTED = 1, held for 10 cycles. STEP pulse → runs exactly one instruction and re-halts at 0x020. Then STEP_MODE = 0 → resumes free-running.
6. N_BOOTED raised at UADDR 0x043 → next edge gives UADDR = 0x000, state BOOT. RST asserted asynchronously mid-cycle → outputs reset immediately, without a clock edge.

Source files
------------

// File: rtl/microop_sequencer_if.sv
// Bundle of the microcode sequencer signals between control_logic and the
// sequencer. The master side (control_logic / test harness) drives the
// control-word fields, opword/bus opcode sources, debug and boot controls,
// and observes the microcode address and status. The slave side is the
// sequencer itself.
//
// Control-side signals (master -> slave):
//   N_BOOTED         high holds the sequencer in BOOT
//   CTRL_MISC        control word bit 15, reset micro-op counter
//   CTRL_IN_PLANE    control word bits 14:12
//   CTRL_OPCODE_SEL  control word bit 22; 0 = opword, 1 = bus
//   OPWORD_OPCODE    opword[31:26]
//   BUS_LOW          bus[5:0]
//   STALL            datapath not ready; freezes sequencing
//   HALT_REQ         halt at next instruction boundary (level)
//   STEP_MODE        halt at every instruction boundary
//   STEP             single-cycle release from HALTED
//   FAULT_CLR        clears sticky FAULT
// Status signals (slave -> master):
//   UADDR            microcode address {OPCODE, COUNT}
//   OPCODE           opcode register
//   COUNT            micro-op counter
//   UOP_VALID        current control word may take effect
//   HALTED           sequencer is halted
//   BOUNDARY         FETCH opcode committed this cycle
//   FAULT            sticky counter overflow flag
interface microop_sequencer_if;
    logic        N_BOOTED;
    logic        CTRL_MISC;
    logic [2:0]  CTRL_IN_PLANE;
    logic        CTRL_OPCODE_SEL;
    logic [5:0]  OPWORD_OPCODE;
    logic [5:0]  BUS_LOW;
    logic        STALL;
    logic        HALT_REQ;
    logic        STEP_MODE;
    logic        STEP;
    logic        FAULT_CLR;

    logic [10:0] UADDR;
    logic [5:0]  OPCODE;
    logic [4:0]  COUNT;
    logic        UOP_VALID;
    logic        HALTED;
    logic        BOUNDARY;
    logic        FAULT;

    modport master (
        output N_BOOTED, CTRL_MISC, CTRL_IN_PLANE, CTRL_OPCODE_SEL,
               OPWORD_OPCODE, BUS_LOW, STALL, HALT_REQ, STEP_MODE,
               STEP, FAULT_CLR,
        input  UADDR, OPCODE, COUNT, UOP_VALID, HALTED, BOUNDARY, FAULT
    );

    modport slave (
        input  N_BOOTED, CTRL_MISC, CTRL_IN_PLANE, CTRL_OPCODE_SEL,
               OPWORD_OPCODE, BUS_LOW, STALL, HALT_REQ, STEP_MODE,
               STEP, FAULT_CLR,
        output UADDR, OPCODE, COUNT, UOP_VALID, HALTED, BOUNDARY, FAULT
    );
endinterface

// File: rtl/microop_sequencer.sv
// Microcode sequencer: owns the opcode register and micro-op counter and
// forms the 11-bit microcode ROM address {OPCODE, COUNT}. Adds boot gating,
// datapath stall, debug halt / single-step at instruction boundaries and
// recovery from a runaway micro-op counter.
//
// Ports:
//   CLK  system clock, rising edge
//   RST  asynchronous active-high reset
//   seq  sequencer side of microop_sequencer_if (control word fields,
//        opcode sources, debug/boot controls in; address and status out)
module microop_sequencer #(
    parameter logic [5:0] RESET_OPCODE  = 6'd0,
    parameter logic [5:0] FETCH_OPCODE  = 6'd1,
    parameter logic [2:0] IN_OPCODE_SEL = 3'd6
) (
    input  logic                    CLK,
    input  logic                    RST,
    microop_sequencer_if.slave      seq
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALTED
    } state_e;

    state_e     state_q, state_d;
    logic [5:0] opcode_q, opcode_d;
    logic [4:0] count_q, count_d;
    logic       fault_q, fault_d;

    logic       boundary;
    logic       fault_set;
    logic       opc_wr;
    logic [5:0] opc_new;
    logic       overflow;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_BOOT;
            opcode_q <= RESET_OPCODE;
            count_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            count_q  <= count_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        count_d   = count_q;
        boundary  = 1'b0;
        fault_set = 1'b0;

        opc_wr   = (seq.CTRL_IN_PLANE == IN_OPCODE_SEL);
        opc_new  = seq.CTRL_OPCODE_SEL ? seq.BUS_LOW : seq.OPWORD_OPCODE;
        // A counter at its last slot that is not being reset would wrap
        // into the same instruction; treat that as a runaway microprogram.
        overflow = (count_q == '1) && !seq.CTRL_MISC;

        if (seq.N_BOOTED) begin
            // Boot gating overrides everything, even mid-instruction.
            state_d  = ST_BOOT;
            opcode_d = RESET_OPCODE;
            count_d  = '0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_d  = ST_RUN;
                    opcode_d = RESET_OPCODE;
                    count_d  = '0;
                end

                ST_RUN: begin
                    if (!seq.STALL) begin
                        if (overflow) begin
                            opcode_d  = RESET_OPCODE;
                            count_d   = '0;
                            fault_set = 1'b1;
                        end else begin
                            count_d = seq.CTRL_MISC ? '0 : count_q + 5'd1;
                            if (opc_wr) begin
                                opcode_d = opc_new;
                                if (seq.CTRL_MISC && (opc_new == FETCH_OPCODE)) begin
                                    boundary = 1'b1;
                                    if (seq.HALT_REQ || seq.STEP_MODE) begin
                                        state_d  = ST_HALTED;
                                        opcode_d = FETCH_OPCODE;
                                        count_d  = '0;
                                    end
                                end
                            end
                        end
                    end
                end

                ST_HALTED: begin
                    if (seq.STEP || (!seq.HALT_REQ && !seq.STEP_MODE)) begin
                        state_d = ST_RUN;
                    end
                end

                default: begin
                    state_d  = ST_BOOT;
                    opcode_d = RESET_OPCODE;
                    count_d  = '0;
                end
            endcase
        end

        // Set beats clear when both land on the same edge.
        if (fault_set) begin
            fault_d = 1'b1;
        end else if (seq.FAULT_CLR) begin
            fault_d = 1'b0;
        end else begin
            fault_d = fault_q;
        end
    end

    assign seq.UADDR     = {opcode_q, count_q};
    assign seq.OPCODE    = opcode_q;
    assign seq.COUNT     = count_q;
    assign seq.UOP_VALID = (state_q == ST_RUN) && !seq.STALL;
    assign seq.HALTED    = (state_q == ST_HALTED);
    assign seq.BOUNDARY  = boundary;
    assign seq.FAULT     = fault_q;

endmodule
